// File: rtl/regalu_pkg.sv
// Shared encodings for the regfile/ALU issue controller: instruction classes,
// field bit positions, FSM states and the ALU opcodes the controller forwards.
package regalu_pkg;

  typedef enum logic [1:0] {
    CLS_R   = 2'b00,
    CLS_I   = 2'b01,
    CLS_CMP = 2'b10,
    CLS_ILL = 2'b11
  } cls_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  localparam int CLS_HI = 31;
  localparam int CLS_LO = 30;
  localparam int ALU_HI = 29;
  localparam int ALU_LO = 27;
  localparam int RD_HI  = 26;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 19;
  localparam int RS2_HI = 18;
  localparam int RS2_LO = 15;
  localparam int IMM_HI = 14;
  localparam int IMM_LO = 0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

// File: rtl/regalu_instr_decode.sv
// Combinational instruction field slicer and imm15 extender (IMM_SEXT selects
// sign- or zero-extension to DATA_W).
module regalu_instr_decode
  import regalu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic [31:0]       instr,
  output cls_e              cls,
  output logic [2:0]        alu_op,
  output logic [3:0]        rd,
  output logic [3:0]        rs1,
  output logic [3:0]        rs2,
  output logic [DATA_W-1:0] imm_ext
);

  function automatic logic [DATA_W-1:0] ext_imm(input logic [14:0] imm);
    if (IMM_SEXT)
      return {{(DATA_W-15){imm[14]}}, imm};
    else
      return {{(DATA_W-15){1'b0}}, imm};
  endfunction

  assign cls     = cls_e'(instr[CLS_HI:CLS_LO]);
  assign alu_op  = instr[ALU_HI:ALU_LO];
  assign rd      = instr[RD_HI:RD_LO];
  assign rs1     = instr[RS1_HI:RS1_LO];
  assign rs2     = instr[RS2_HI:RS2_LO];
  assign imm_ext = ext_imm(instr[IMM_HI:IMM_LO]);

endmodule

// File: rtl/regalu_issue_ctrl.sv
// Multi-cycle issue/writeback controller driving an external regfile and ALU.
// Optional REGALU_ISSUE_PERF_EN adds retired_cnt/zero_cnt response counters.
module regalu_issue_ctrl
  import regalu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit IMM_SEXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [3:0]        read_reg1,
  output logic [3:0]        read_reg2,
  input  logic [DATA_W-1:0] read_data1,
  input  logic [DATA_W-1:0] read_data2,
  output logic [3:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              reg_write,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic              resp_err
`ifdef REGALU_ISSUE_PERF_EN
  ,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       zero_cnt
`endif
);

  state_e            state, state_nxt;
  logic [31:0]       ir;
  logic [DATA_W-1:0] op_a, op_b, result;
  logic              zero_q, err_q;
  logic [3:0]        rr1_q, rr2_q;

  cls_e              ir_cls;
  logic [2:0]        ir_op;
  logic [3:0]        ir_rd, ir_rs1, ir_rs2;
  logic [DATA_W-1:0] ir_imm;
  cls_e              in_cls;

  regalu_instr_decode #(
    .DATA_W   (DATA_W),
    .IMM_SEXT (IMM_SEXT)
  ) u_decode (
    .instr   (ir),
    .cls     (ir_cls),
    .alu_op  (ir_op),
    .rd      (ir_rd),
    .rs1     (ir_rs1),
    .rs2     (ir_rs2),
    .imm_ext (ir_imm)
  );

  assign in_cls = cls_e'(instr[CLS_HI:CLS_LO]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    reg_write   = 1'b0;
    resp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid)
          state_nxt = (in_cls == CLS_ILL) ? ST_RESP : ST_READ;
      end
      ST_READ: state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = (ir_cls == CLS_CMP) ? ST_RESP : ST_WB;
      ST_WB: begin
        reg_write = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath captures: IR on accept, operands in READ, ALU outputs in EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      zero_q <= 1'b0;
      err_q  <= 1'b0;
      rr1_q  <= '0;
      rr2_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            ir     <= instr;
            err_q  <= (in_cls == CLS_ILL);
            result <= '0;
            zero_q <= 1'b0;
          end
        end
        ST_READ: begin
          rr1_q <= ir_rs1;
          rr2_q <= ir_rs2;
          op_a  <= read_data1;
          op_b  <= (ir_cls == CLS_I) ? ir_imm : read_data2;
        end
        ST_EXEC: begin
          result <= alu_result;
          zero_q <= alu_zero;
        end
        default: ;
      endcase
    end
  end

  assign read_reg1   = (state == ST_READ) ? ir_rs1 : rr1_q;
  assign read_reg2   = (state == ST_READ) ? ir_rs2 : rr2_q;
  assign alu_a       = op_a;
  assign alu_b       = op_b;
  assign alu_ctrl    = ir_op;
  assign write_reg   = ir_rd;
  assign write_data  = result;
  assign resp_result = result;
  assign resp_zero   = zero_q;
  assign resp_err    = err_q;

`ifdef REGALU_ISSUE_PERF_EN
  // Only legal instructions retire; illegal responses leave both counters alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt <= '0;
      zero_cnt    <= '0;
    end else if (resp_valid && resp_ready && !err_q) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (zero_q) zero_cnt <= zero_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regalu_issue_ctrl.sv
// Directed bench for regalu_issue_ctrl: two instances (sign- and zero-extending
// immediates) run in lockstep, each with its own regfile and ALU model.
module tb_regalu_issue_ctrl;
  import regalu_pkg::*;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          instr_valid = 1'b0;
  logic          resp_ready  = 1'b0;
  logic [31:0]   instr       = '0;

  logic          irdy_s, we_s, rv_s, rz_s, re_s, az_s;
  logic [3:0]    rr1_s, rr2_s, wr_s;
  logic [2:0]    ctl_s;
  logic [DW-1:0] rd1_s, rd2_s, wd_s, a_s, b_s, ares_s, rres_s;
  logic          irdy_z, we_z, rv_z, rz_z, re_z, az_z;
  logic [3:0]    rr1_z, rr2_z, wr_z;
  logic [2:0]    ctl_z;
  logic [DW-1:0] rd1_z, rd2_z, wd_z, a_z, b_z, ares_z, rres_z;
`ifdef REGALU_ISSUE_PERF_EN
  logic [31:0]   ret_s, zc_s, ret_z, zc_z;
`endif

  logic [DW-1:0] rf_s [16] = '{default: '0};
  logic [DW-1:0] rf_z [16] = '{default: '0};

  int total = 0;
  int bad   = 0;
  int lat, wrn;

  function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [31:0] enc(input cls_e c, input logic [2:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2, input logic [14:0] imm);
    return {c, op, rd, rs1, rs2, imm};
  endfunction

  assign rd1_s  = rf_s[rr1_s];
  assign rd2_s  = rf_s[rr2_s];
  assign ares_s = alu_f(ctl_s, a_s, b_s);
  assign az_s   = (ares_s == '0);
  assign rd1_z  = rf_z[rr1_z];
  assign rd2_z  = rf_z[rr2_z];
  assign ares_z = alu_f(ctl_z, a_z, b_z);
  assign az_z   = (ares_z == '0);

  always @(posedge clk) begin
    if (we_s) rf_s[wr_s] <= wd_s;
    if (we_z) rf_z[wr_z] <= wd_z;
  end

  regalu_issue_ctrl #(.DATA_W(DW), .IMM_SEXT(1'b1)) dut_s (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(irdy_s), .instr(instr),
    .read_reg1(rr1_s), .read_reg2(rr2_s), .read_data1(rd1_s), .read_data2(rd2_s),
    .write_reg(wr_s), .write_data(wd_s), .reg_write(we_s),
    .alu_a(a_s), .alu_b(b_s), .alu_ctrl(ctl_s), .alu_result(ares_s), .alu_zero(az_s),
    .resp_valid(rv_s), .resp_ready(resp_ready), .resp_result(rres_s), .resp_zero(rz_s), .resp_err(re_s)
`ifdef REGALU_ISSUE_PERF_EN
    , .retired_cnt(ret_s), .zero_cnt(zc_s)
`endif
  );

  regalu_issue_ctrl #(.DATA_W(DW), .IMM_SEXT(1'b0)) dut_z (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(irdy_z), .instr(instr),
    .read_reg1(rr1_z), .read_reg2(rr2_z), .read_data1(rd1_z), .read_data2(rd2_z),
    .write_reg(wr_z), .write_data(wd_z), .reg_write(we_z),
    .alu_a(a_z), .alu_b(b_z), .alu_ctrl(ctl_z), .alu_result(ares_z), .alu_zero(az_z),
    .resp_valid(rv_z), .resp_ready(resp_ready), .resp_result(rres_z), .resp_zero(rz_z), .resp_err(re_z)
`ifdef REGALU_ISSUE_PERF_EN
    , .retired_cnt(ret_z), .zero_cnt(zc_z)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction, then count cycles to resp_valid and reg_write pulses.
  task automatic issue(input logic [31:0] w, output int l, output int n);
    instr       = w;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    l = 1;
    n = 0;
    while (!rv_s && l < 20) begin
      if (we_s) n++;
      tick();
      l++;
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("ready_after_resp", {31'd0, irdy_s}, 32'd1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_instr_ready", {31'd0, irdy_s}, 32'd1);
    chk("rst_resp_valid",  {31'd0, rv_s},   32'd0);
    chk("rst_reg_write",   {31'd0, we_s},   32'd0);
    chk("rst_resp_err",    {31'd0, re_s},   32'd0);
    chk("rst_resp_zero",   {31'd0, rz_s},   32'd0);
    chk("rst_resp_result", rres_s,          32'd0);
    rst = 1'b0;
    tick();

    issue(enc(CLS_I, ALU_ADD, 4'd1, 4'd0, 4'd0, 15'd10), lat, wrn);
    chk("i1_latency", lat, 4);
    chk("i1_writes",  wrn, 1);
    chk("i1_result",  rres_s, 32'd10);
    chk("i1_r1",      rf_s[1], 32'd10);
    handshake();

    issue(enc(CLS_I, ALU_ADD, 4'd2, 4'd0, 4'd0, 15'd20), lat, wrn);
    chk("i2_writes",  wrn, 1);
    chk("i2_result",  rres_s, 32'd20);
    chk("i2_r2",      rf_s[2], 32'd20);
    handshake();

    issue(enc(CLS_R, ALU_ADD, 4'd3, 4'd1, 4'd2, 15'd0), lat, wrn);
    chk("r_latency", lat, 4);
    chk("r_writes",  wrn, 1);
    chk("r_result",  rres_s, 32'd30);
    chk("r_zero",    {31'd0, rz_s}, 32'd0);
    chk("r_r3",      rf_s[3], 32'd30);
    handshake();

    issue(enc(CLS_CMP, ALU_SUB, 4'd9, 4'd1, 4'd1, 15'd0), lat, wrn);
    chk("cmp_latency", lat, 3);
    chk("cmp_writes",  wrn, 0);
    chk("cmp_result",  rres_s, 32'd0);
    chk("cmp_zero",    {31'd0, rz_s}, 32'd1);
    chk("cmp_r9",      rf_s[9], 32'd0);
    handshake();

    issue(enc(CLS_I, ALU_ADD, 4'd4, 4'd0, 4'd0, 15'h7FFF), lat, wrn);
    chk("sext_result", rres_s,  32'hFFFF_FFFF);
    chk("sext_r4",     rf_s[4], 32'hFFFF_FFFF);
    chk("zext_result", rres_z,  32'h0000_7FFF);
    chk("zext_r4",     rf_z[4], 32'h0000_7FFF);
    handshake();

    issue(enc(CLS_ILL, ALU_ADD, 4'd6, 4'd1, 4'd2, 15'd3), lat, wrn);
    chk("ill_latency", lat, 1);
    chk("ill_err",     {31'd0, re_s}, 32'd1);
    chk("ill_result",  rres_s, 32'd0);
    chk("ill_zero",    {31'd0, rz_s}, 32'd0);
    instr       = enc(CLS_R, ALU_ADD, 4'd7, 4'd1, 4'd2, 15'd0);
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", {31'd0, rv_s},   32'd1);
      chk("hold_err",   {31'd0, re_s},   32'd1);
      chk("hold_ready", {31'd0, irdy_s}, 32'd0);
      chk("hold_wr",    {31'd0, we_s},   32'd0);
    end
    instr_valid = 1'b0;
    chk("ill_r6", rf_s[6], 32'd0);
    chk("ill_r7", rf_s[7], 32'd0);
    handshake();

    issue(enc(CLS_R, ALU_SUB, 4'd1, 4'd3, 4'd1, 15'd0), lat, wrn);
    chk("haz_result", rres_s,  32'd20);
    chk("haz_r1",     rf_s[1], 32'd20);
    handshake();
`ifdef REGALU_ISSUE_PERF_EN
    chk("perf_retired", ret_s, 32'd6);
    chk("perf_zero",    zc_s,  32'd1);
`endif

    instr       = enc(CLS_I, ALU_ADD, 4'd5, 4'd1, 4'd0, 15'd5);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("wb_reg_write", {31'd0, we_s}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwb_reg_write", {31'd0, we_s},   32'd0);
    chk("rstwb_ready",     {31'd0, irdy_s}, 32'd1);
    tick();
    chk("rstwb_r5", rf_s[5], 32'd0);
    rst = 1'b0;
    tick();
    chk("rstwb_ready_rel", {31'd0, irdy_s}, 32'd1);
    chk("rstwb_valid_rel", {31'd0, rv_s},   32'd0);
`ifdef REGALU_ISSUE_PERF_EN
    chk("perf_rst_retired", ret_s, 32'd0);
    chk("perf_rst_zero",    zc_s,  32'd0);
    chk("perf_rst_ret_z",   ret_z, 32'd0);
    chk("perf_rst_zero_z",  zc_z,  32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regalu_issue_ctrl.md
Name: regalu_issue_ctrl

Overview:
Multi-cycle issue/writeback controller that drives the existing register file and ALU. It is the initiator side of the regfile/ALU interface that benches currently drive by hand.
- Accepts one encoded 32-bit instruction per valid/ready handshake.
- Sequences register reads, operand selection, ALU execution and register writeback.
- Returns result, zero flag and error on a response handshake.

Parameters:
DATA_W, 32, datapath width (regfile data, ALU operands, result)
IMM_SEXT, 1, 1 = sign-extend imm15 to DATA_W; 0 = zero-extend

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept (high only in IDLE)
instr  in  32  encoded instruction
read_reg1  out  4  regfile read address 1
read_reg2  out  4  regfile read address 2
read_data1  in  DATA_W  regfile read data 1 (combinational)
read_data2  in  DATA_W  regfile read data 2 (combinational)
write_reg  out  4  regfile write address
write_data  out  DATA_W  regfile write data
reg_write  out  1  regfile write enable, one-cycle pulse
alu_a  out  DATA_W  ALU operand a
alu_b  out  DATA_W  ALU operand b
alu_ctrl  out  3  ALU operation
alu_result  in  DATA_W  ALU result (combinational)
alu_zero  in  1  ALU zero flag
resp_valid  out  1  response available
resp_ready  in  1  response consumed
resp_result  out  DATA_W  captured ALU result
resp_zero  out  1  captured zero flag
resp_err  out  1  illegal instruction

Behaviour:
- Reset: one clock `clk`; reset `rst` is asynchronous and active-high.
  - State→IDLE; IR, operand and result registers clear to 0.
  - reg_write, resp_valid, resp_zero and resp_err are 0; instr_ready is 1.
  - Reset mid-operation aborts immediately. A pending writeback is dropped; reg_write never glitches high.
- Instruction fields:
  - [31:30] class: 00 = R (rd←rs1 op rs2); 01 = I (rd←rs1 op imm); 10 = CMP (rs1 op rs2, no writeback); 11 = illegal.
  - [29:27] alu_ctrl; [26:23] rd; [22:19] rs1; [18:15] rs2; [14:0] imm15.
- FSM states: IDLE, READ, EXEC, WB, RESP.
  - IDLE: instr_ready=1. When instr_valid is high, capture instr into IR. Go to RESP if class==11 (resp_err=1, resp_result=0, resp_zero=0), else go to READ.
  - READ: read_reg1=IR.rs1, read_reg2=IR.rs2. Latch opA=read_data1. Latch opB=read_data2 for R/CMP, or the extended imm15 for I. Go to EXEC.
  - EXEC: alu_a=opA, alu_b=opB, alu_ctrl=IR.alu_ctrl. Latch alu_result and alu_zero. Go to WB for R/I, or RESP for CMP.
  - WB: reg_write=1 for exactly this cycle, write_reg=IR.rd, write_data=captured result. Go to RESP.
  - RESP: resp_valid=1; resp_* are stable until resp_ready. On resp_valid&&resp_ready, go to IDLE.
- Output holds:
  - read_reg1/2 hold their last values outside READ.
  - alu_a, alu_b and alu_ctrl hold registered values.
  - write_reg and write_data are don't-care when reg_write=0, but must be driven.
- Latency: instr accepted in cycle T gives resp_valid in T+4 for R/I, T+3 for CMP, T+1 for illegal. The regfile write commits on the clock edge ending cycle T+3.
- Throughput: no new instruction is accepted until the cycle after the response handshake. instr_valid outside IDLE is ignored.
- Register hazards:
  - rd may equal rs1/rs2; reads complete before writeback, so old values are used.
  - rd=0 is written like any other register (no hard-wired zero).
- Arithmetic: the controller performs none; width is DATA_W throughout. The imm15 extension obeys IMM_SEXT.

Optional Feature:
- Macro: REGALU_ISSUE_PERF_EN.
- Defined: adds output ports retired_cnt [31:0] and zero_cnt [31:0].
  - retired_cnt increments on each response handshake where resp_err=0.
  - zero_cnt increments on each such handshake with resp_zero=1.
  - Both wrap modulo 2^32 and clear on rst.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package regalu_pkg holds:
  - the class encodings (CLS_R, CLS_I, CLS_CMP, CLS_ILL);
  - the instruction field bit-position constants;
  - the FSM state encoding;
  - ALU op constants (ALU_ADD=3'b000, ALU_SUB=3'b001).
- One natural sub-module: regalu_instr_decode, a combinational field slicer and immediate extender. The FSM stays in regalu_issue_ctrl.

Test Plan:
- After reset, issue I-type ADD rd=1, rs1=0, imm=10 (r0=0), then rd=2 imm=20 → r1=10, r2=20; reg_write pulses exactly once each; resp_result 10 and 20.
- R-type ADD rd=3, rs1=1, rs2=2 → resp_result=30, resp_zero=0, r3=30; resp_valid 4 cycles after acceptance.
- CMP SUB rs1=1, rs2=1 → resp_result=0, resp_zero=1, no reg_write pulse, latency 3.
- I-type ADD rd=4, rs1=0, imm=15'h7FFF: with IMM_SEXT=1 → r4=32'hFFFFFFFF; with IMM_SEXT=0 → 32'h00007FFF.
- Class 11 instruction → resp_err=1 next cycle, no regfile write. Hold resp_ready=0 for 5 cycles → resp_* stable and instr_ready=0 throughout.
- Assert rst during WB → reg_write low immediately, target register unchanged, instr_ready=1 after release. With REGALU_ISSUE_PERF_EN, counters read 0.
